// File: rtl/nhan_bonus_pkg.sv
// Shared constants, field layout and FSM encoding for the nhan_bonus
// single-precision multiplier.
package nhan_bonus_pkg;

  localparam int MANT_W  = 23;
  localparam int EXP_W   = 8;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

endpackage

// File: rtl/nhan_bonus_mant_mul.sv
// Sequential 24x24 shift-and-add significand multiplier: one multiplier
// bit (LSB first) per clock, done held high until the next load.
module nhan_bonus_mant_mul
  import nhan_bonus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [MANT_W:0]        mcand,
  input  logic [MANT_W:0]        mplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*MANT_W+1:0]    prod
);

  logic [2*MANT_W+1:0] acc_r;
  logic [2*MANT_W+1:0] mcand_r;
  logic [MANT_W:0]     mplier_r;
  logic [4:0]          cnt_r;
  logic                busy_r;
  logic                done_r;

  // Accumulate one shifted partial product per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{(MANT_W+1){1'b0}}, mcand};
      mplier_r <= mplier;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (cnt_r == 5'd23) begin
        cnt_r  <= cnt_r;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + 5'd1;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
      busy_r   <= busy_r;
      done_r   <= done_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign prod = acc_r;

endmodule

// File: rtl/nhan_bonus.sv
// Multi-cycle IEEE-754 single-precision multiplier (truncating) with
// overflow/underflow flags; results land 26 cycles after operand capture.
module nhan_bonus
  import nhan_bonus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        underflow,
  output logic        overflow
);

  state_t       state_r, state_s;
  logic [31:0]  cap_a_r, cap_b_r;
  logic         first_r;
  logic         load_s, commit_s, changed_s;
  logic         mul_busy_s, mul_done_s;
  logic [47:0]  prod_s;
  fp32_t        fa_s, fb_s;
  logic         sign_s;
  logic signed [10:0] e_s;
  logic [MANT_W-1:0]  frac_s;
  logic [31:0]  res_s;
  logic         res_of_s, res_uf_s;
  logic         unused_s;

  assign fa_s      = cap_a_r;
  assign fb_s      = cap_b_r;
  assign changed_s = ({A, B} != {cap_a_r, cap_b_r});

  nhan_bonus_mant_mul u_mant_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .mcand  ({1'b1, A[MANT_W-1:0]}),
    .mplier ({1'b1, B[MANT_W-1:0]}),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .prod   (prod_s)
  );

  // State, operand capture and the first-after-reset capture request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cap_a_r <= 32'h0;
      cap_b_r <= 32'h0;
      first_r <= 1'b1;
    end else if (load_s) begin
      state_r <= state_s;
      cap_a_r <= A;
      cap_b_r <= B;
      first_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cap_a_r <= cap_a_r;
      cap_b_r <= cap_b_r;
      first_r <= first_r;
    end
  end

  // Next state; any operand change in MUL/NORM recaptures immediately.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (first_r || changed_s) begin
          load_s  = 1'b1;
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (changed_s) begin
          load_s  = 1'b1;
          state_s = MUL;
        end else if (mul_done_s && !mul_busy_s) begin
          state_s = NORM;
        end else begin
          state_s = MUL;
        end
      end
      NORM: begin
        if (changed_s) begin
          load_s  = 1'b1;
          state_s = MUL;
        end else begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign sign_s   = fa_s.sign ^ fb_s.sign;
  assign e_s      = $signed({3'b000, fa_s.exp}) + $signed({3'b000, fb_s.exp})
                  - $signed(11'(BIAS)) + $signed({10'b0, prod_s[47]});
  assign frac_s   = prod_s[47] ? prod_s[46:24] : prod_s[45:23];
  assign unused_s = ^prod_s[22:0];

  // Special-case priority and final packing of the result.
  always_comb begin
    res_s    = {sign_s, 31'h0};
    res_of_s = 1'b0;
    res_uf_s = 1'b0;
    if (fa_s.exp == 8'hFF || fb_s.exp == 8'hFF) begin
      res_s    = {sign_s, 8'hFF, 23'h0};
      res_of_s = 1'b1;
    end else if ((fa_s.exp == 8'h00 && fa_s.frac == 23'h0) ||
                 (fb_s.exp == 8'h00 && fb_s.frac == 23'h0)) begin
      res_s = {sign_s, 31'h0};
    end else if (fa_s.exp == 8'h00 || fb_s.exp == 8'h00) begin
      res_s    = {sign_s, 31'h0};
      res_uf_s = 1'b1;
    end else if (e_s >= $signed(11'(EXP_MAX))) begin
      res_s    = {sign_s, 8'hFF, 23'h0};
      res_of_s = 1'b1;
    end else if (e_s <= 11'sd0) begin
      res_s    = {sign_s, 31'h0};
      res_uf_s = 1'b1;
    end else begin
      res_s = {sign_s, e_s[7:0], frac_s};
    end
  end

  // Outputs change only when a NORM cycle completes unaborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 32'h0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (commit_s) begin
      out       <= res_s;
      underflow <= res_uf_s;
      overflow  <= res_of_s;
    end else begin
      out       <= out;
      underflow <= underflow;
      overflow  <= overflow;
    end
  end

endmodule

// File: tb/tb_nhan_bonus.sv
// Self-checking bench for nhan_bonus: directed vectors, random operands
// against an arithmetic reference model, abort and async reset.
module tb_nhan_bonus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [31:0] out;
  logic        underflow, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] prev;

  always #5 clk = ~clk;

  nhan_bonus dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .out       (out),
    .underflow (underflow),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // exp packs {overflow, underflow, out}
  task automatic check_all(input string tag, input logic [33:0] exp);
    check_eq({tag, ".out"}, out, exp[31:0]);
    check_eq({tag, ".uf"}, {31'h0, underflow}, {31'h0, exp[32]});
    check_eq({tag, ".of"}, {31'h0, overflow}, {31'h0, exp[33]});
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned ma, mb, p, fr;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    if (ea == 255 || eb == 255) return {2'b10, s, 8'hFF, 23'h0};
    if ((ea == 0 && a[22:0] == 23'h0) || (eb == 0 && b[22:0] == 23'h0))
      return {2'b00, s, 31'h0};
    if (ea == 0 || eb == 0) return {2'b01, s, 31'h0};
    p = ma * mb;
    e = ea + eb - 127;
    if (p >= 64'd140737488355328) begin
      e  = e + 1;
      fr = (p / 64'd16777216) % 64'd8388608;
    end else begin
      fr = (p / 64'd8388608) % 64'd8388608;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, s, 31'h0};
    return {2'b00, s, e[7:0], fr[22:0]};
  endfunction

  // Drive at a negedge; capture is the following posedge, result 26 edges later.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [33:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    repeat (26) @(posedge clk);
    #1 check_all({tag, ".hold"}, prev);
    @(posedge clk);
    #1 check_all(tag, exp);
    prev = exp;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 10));
      3:       e = 8'($urandom_range(245, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e,
            ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    A     = 32'h0;
    B     = 32'h0;
    prev  = 34'h0;
    #12;
    check_all("reset", 34'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("vec1", 32'h3F700000, 32'h3DB00000, {2'b00, 32'h3DA50000});
    run_op("vec2", 32'h3F500000, 32'hBED00000, {2'b00, 32'hBEA90000});
    run_op("vec3", 32'h3FD00000, 32'hBF500000, {2'b00, 32'hBFA90000});
    run_op("vec4_of", 32'h7F500000, 32'hBFD00000, {2'b10, 32'hFF800000});
    run_op("vec5_dn", 32'h00500000, 32'hBED00000, {2'b01, 32'h80000000});
    run_op("zero", 32'h80000000, 32'h3F800000, {2'b00, 32'h80000000});
    run_op("inf_zero", 32'h7F800000, 32'h00000000, {2'b10, 32'h7F800000});
    run_op("uf_small", 32'h00800000, 32'h3E800000, {2'b01, 32'h00000000});

    for (int i = 0; i < 24; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      if ({ra, rb} == {A, B}) ra = ra ^ 32'h00000001;
      run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
    end

    // Abort: change B ten cycles into MUL; only the final operands report.
    @(negedge clk);
    A = 32'h3F700000;
    B = 32'h3DB00000;
    repeat (11) @(posedge clk);
    #1 check_all("abort.mid", prev);
    @(negedge clk);
    B = 32'hBED00000;
    repeat (26) @(posedge clk);
    #1 check_all("abort.hold", prev);
    @(posedge clk);
    #1 check_all("abort.res", model(32'h3F700000, 32'hBED00000));
    prev = model(32'h3F700000, 32'hBED00000);

    // Async reset mid-MUL clears outputs at once; caller's operands rerun.
    @(negedge clk);
    A = 32'h3FD00000;
    B = 32'hBF500000;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("rst.async", 34'h0);
    prev = 34'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (26) @(posedge clk);
    #1 check_all("rst.hold", prev);
    @(posedge clk);
    #1 check_all("rst.res", {2'b00, 32'hBFA90000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
